// File: rtl/ped_request.sv
`default_nettype none
// ============================================================================
// Module      : ped_request
// Description : Pedestrian push-button front end for the traffic-light
//               controller. Two identical, independent channels turn an
//               asynchronous active-low key into a clean pending-request flag:
//                 key -> 2-flop synchronizer -> debounce filter
//                     -> press (0->1) detect -> request FSM (IDLE/PENDING
//                        [/LOCKOUT]) held until the controller acknowledges.
//
// Parameters  : DB_CYCLES       consecutive stable cycles to accept a level
//                               change (>= 2)
//               LOCKOUT_CYCLES  post-acknowledge ignore window in cycles
//                               (>= 1), only meaningful with the macro below
//
// Ports       : clk50M          50 MHz system clock
//               Reset           synchronous, active-low reset
//               KEY1 / KEY2     raw buttons, asynchronous, 0 = pressed
//               ack1 / ack2     controller served the request (pulse or level)
//               req1 / req2     request pending (registered)
//               pressed1/2      debounced button level, 1 = held (registered)
//
// Config      : PED_REQ_LOCKOUT_EN
//               defined   -> PENDING + ack enters LOCKOUT for LOCKOUT_CYCLES
//                            cycles, during which presses are discarded
//               undefined -> PENDING + ack returns straight to IDLE, no
//                            lockout logic is built
//
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request #(
    parameter int unsigned DB_CYCLES      = 1_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk50M,
    input  logic Reset,
    input  logic KEY1,
    input  logic KEY2,
    input  logic ack1,
    input  logic ack2,
    output logic req1,
    output logic req2,
    output logic pressed1,
    output logic pressed2
);

    localparam int unsigned NUM_CH = 2;

    // Debounce counter only has to reach DB_CYCLES-1.
    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

`ifdef PED_REQ_LOCKOUT_EN
    // Lockout counter runs 0 .. LOCKOUT_CYCLES-1 while in LOCKOUT.
    localparam int unsigned LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOCKOUT = 2'd2
    } req_state_e;

    // Parameter range hook: a build with DB_CYCLES < 2 or LOCKOUT_CYCLES < 1
    // is outside the supported range; the block elaborates to nothing extra.
    if ((DB_CYCLES < 2) || (LOCKOUT_CYCLES < 1)) begin : g_param_range
    end

    // Channel-indexed views of the scalar ports.
    logic [NUM_CH-1:0] key_n;
    logic [NUM_CH-1:0] ack_in;
    logic [NUM_CH-1:0] req_vec;
    logic [NUM_CH-1:0] pressed_vec;

    assign key_n  = {KEY2, KEY1};
    assign ack_in = {ack2, ack1};

    assign req1     = req_vec[0];
    assign req2     = req_vec[1];
    assign pressed1 = pressed_vec[0];
    assign pressed2 = pressed_vec[1];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan

        // Synchronizer; the key is inverted so 1 means "pressed".
        logic             sync1_q;
        logic             sync2_q;

        // Debounce filter.
        logic             stable_q;
        logic             stable_d;
        logic [DB_W-1:0]  db_cnt_q;
        logic [DB_W-1:0]  db_cnt_d;

        // Request FSM.
        req_state_e       state_q;
        req_state_e       state_d;
        logic             req_q;
        logic             req_d;
        logic             press_evt;

`ifdef PED_REQ_LOCKOUT_EN
        logic [LK_W-1:0]  lock_cnt_q;
        logic [LK_W-1:0]  lock_cnt_d;
`endif

        always_comb begin
            // Count consecutive cycles in which the synchronized level
            // disagrees with the accepted level; any agreement restarts
            // the count, so a short glitch never gets through.
            stable_d = stable_q;
            db_cnt_d = '0;
            if (sync2_q != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            // Press event is taken from the next-state level so the request
            // rises on the very edge that accepts the press.
            press_evt = stable_d & ~stable_q;

            state_d = state_q;
`ifdef PED_REQ_LOCKOUT_EN
            lock_cnt_d = '0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (press_evt) begin
                        state_d = ST_PENDING;
                    end
                end

                ST_PENDING: begin
                    // A press coinciding with ack is a fresh request and
                    // keeps the channel pending.
                    if (ack_in[ch] && !press_evt) begin
`ifdef PED_REQ_LOCKOUT_EN
                        state_d = ST_LOCKOUT;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end

`ifdef PED_REQ_LOCKOUT_EN
                ST_LOCKOUT: begin
                    // The last lockout edge already behaves as IDLE: a press
                    // accepted on that edge is kept.
                    if (lock_cnt_q == LK_LAST) begin
                        state_d = press_evt ? ST_PENDING : ST_IDLE;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LK_W'(1);
                    end
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            req_d = (state_d == ST_PENDING);
        end

        always_ff @(posedge clk50M) begin
            if (!Reset) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                stable_q   <= 1'b0;
                db_cnt_q   <= '0;
                state_q    <= ST_IDLE;
                req_q      <= 1'b0;
`ifdef PED_REQ_LOCKOUT_EN
                lock_cnt_q <= '0;
`endif
            end else begin
                sync1_q    <= ~key_n[ch];
                sync2_q    <= sync1_q;
                stable_q   <= stable_d;
                db_cnt_q   <= db_cnt_d;
                state_q    <= state_d;
                req_q      <= req_d;
`ifdef PED_REQ_LOCKOUT_EN
                lock_cnt_q <= lock_cnt_d;
`endif
            end
        end

        assign req_vec[ch]     = req_q;
        assign pressed_vec[ch] = stable_q;

    end : g_chan

endmodule : ped_request
`default_nettype wire

// File: tb/tb_ped_request.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_request
// Description : Directed bench for ped_request (DB_CYCLES=4, LOCKOUT_CYCLES=10).
//               Stimulus pushes each hand-computed output change, as
//               {edge number, {req2,pressed2,req1,pressed1}}, into a queue;
//               a monitor pops one entry whenever the outputs change and
//               compares both the edge and the value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_request;

    logic clk50M = 1'b0;
    logic Reset;
    logic KEY1, KEY2;
    logic ack1, ack2;
    logic req1, req2;
    logic pressed1, pressed2;

    ped_request #(
        .DB_CYCLES      (4),
        .LOCKOUT_CYCLES (10)
    ) u_dut (
        .clk50M   (clk50M),
        .Reset    (Reset),
        .KEY1     (KEY1),
        .KEY2     (KEY2),
        .ack1     (ack1),
        .ack2     (ack2),
        .req1     (req1),
        .req2     (req2),
        .pressed1 (pressed1),
        .pressed2 (pressed2)
    );

    always #5 clk50M = ~clk50M;

    // Number of rising edges seen so far; read at falling edges.
    int edge_n = 0;
    always @(posedge clk50M) edge_n <= edge_n + 1;

    logic [3:0] obs;
    assign obs = {req2, pressed2, req1, pressed1};

    int         exp_t_q[$];
    logic [3:0] exp_v_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] prev_v   = 4'b0000;

    task automatic push(input int t, input logic [3:0] v);
        exp_t_q.push_back(t);
        exp_v_q.push_back(v);
    endtask

    task automatic wait_to(input int t);
        while (edge_n < t) @(negedge clk50M);
    endtask

    // Monitor: every output change must match the next expected change.
    always @(negedge clk50M) begin
        int         t;
        logic [3:0] v;
        if (obs !== prev_v) begin
            checks++;
            if (exp_t_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change edge=%0d got=%b expected no change from %b",
                         edge_n, obs, prev_v);
            end else begin
                t = exp_t_q.pop_front();
                v = exp_v_q.pop_front();
                if ((t != edge_n) || (v !== obs)) begin
                    failures++;
                    $display("FAIL event got edge=%0d value=%b expected edge=%0d value=%b",
                             edge_n, obs, t, v);
                end
            end
            prev_v = obs;
        end
    end

    initial begin
        Reset = 1'b0;
        KEY1  = 1'b0;
        KEY2  = 1'b0;
        ack1  = 1'b0;
        ack2  = 1'b0;

        // Reset held for 3 edges with both keys pressed: outputs stay 0.
        repeat (3) begin
            @(negedge clk50M);
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs edge=%0d got=%b expected=0000", edge_n, obs);
            end
        end
        Reset = 1'b1;                       // first sampling edge is 4
        push(9, 4'b1111);                   // 5 edges later both requests rise

        wait_to(10); KEY1 = 1'b1; KEY2 = 1'b1;
        push(16, 4'b1010);                  // release: pressed falls, req held
        wait_to(17); ack1 = 1'b1; ack2 = 1'b1;
        push(18, 4'b0000);
        wait_to(18); ack1 = 1'b0; ack2 = 1'b0;

        // Bounce: 3 low, 1 high, 3 low never reaches 4 stable cycles.
        wait_to(22); KEY1 = 1'b0;
        wait_to(25); KEY1 = 1'b1;
        wait_to(26); KEY1 = 1'b0;
        wait_to(29); KEY1 = 1'b1;
        // Held 10 cycles: accepted at E+5.
        wait_to(35); KEY1 = 1'b0; push(41, 4'b0011);
        wait_to(45); KEY1 = 1'b1; push(51, 4'b0010);
        wait_to(53); ack1 = 1'b1; push(54, 4'b0000);
        wait_to(54); ack1 = 1'b0;

        // Concurrent channels with offset presses; ack1 leaves req2 alone.
        wait_to(60); KEY1 = 1'b0; push(66, 4'b0011);
        wait_to(62); KEY2 = 1'b0; push(68, 4'b1111);
        wait_to(70); KEY1 = 1'b1; push(76, 4'b1110);
        wait_to(72); KEY2 = 1'b1; push(78, 4'b1010);
        wait_to(80); ack1 = 1'b1; push(81, 4'b1000);
        wait_to(81); ack1 = 1'b0;
        wait_to(83); ack2 = 1'b1; push(84, 4'b0000);
        wait_to(84); ack2 = 1'b0;

        // Collision: new press accepted on the ack edge keeps req1 high.
        wait_to(90);  KEY1 = 1'b0; push(96,  4'b0011);
        wait_to(98);  KEY1 = 1'b1; push(104, 4'b0010);
        wait_to(106); KEY1 = 1'b0; push(112, 4'b0011);
        wait_to(111); ack1 = 1'b1;          // sampled on edge 112
        wait_to(112); ack1 = 1'b0;
        wait_to(114); KEY1 = 1'b1; push(120, 4'b0010);
        wait_to(122); ack1 = 1'b1; push(123, 4'b0000);
        wait_to(123); ack1 = 1'b0;

        // Lockout scenario: ack at edge 147, press done at 150 (ack+3),
        // release at 155, press done at 159 (ack+12).
        wait_to(130); KEY1 = 1'b0; push(136, 4'b0011);
        wait_to(137); KEY1 = 1'b1; push(143, 4'b0010);
        wait_to(144); KEY1 = 1'b0;
        wait_to(146); ack1 = 1'b1; push(147, 4'b0000);
`ifdef PED_REQ_LOCKOUT_EN
        push(150, 4'b0001);                 // discarded during lockout
`else
        push(150, 4'b0011);                 // accepted in IDLE
`endif
        wait_to(147); ack1 = 1'b0;
        wait_to(149); KEY1 = 1'b1;
`ifdef PED_REQ_LOCKOUT_EN
        push(155, 4'b0000);
`else
        push(155, 4'b0010);
`endif
        wait_to(153); KEY1 = 1'b0; push(159, 4'b0011);
        wait_to(161); KEY1 = 1'b1; push(167, 4'b0010);
        wait_to(169); ack1 = 1'b1; push(170, 4'b0000);
        wait_to(170); ack1 = 1'b0;

        // Reset mid-debounce restarts the filter from scratch.
        wait_to(176); KEY2  = 1'b0;
        wait_to(179); Reset = 1'b0;
        wait_to(180); Reset = 1'b1; push(186, 4'b1100);
        wait_to(188); KEY2 = 1'b1; push(194, 4'b1000);
        wait_to(196); ack2 = 1'b1; push(197, 4'b0000);
        wait_to(197); ack2 = 1'b0;

        // Ack while IDLE is ignored: no output change expected.
        wait_to(200); ack1 = 1'b1; ack2 = 1'b1;
        wait_to(202); ack1 = 1'b0; ack2 = 1'b0;

        wait_to(215);
        while (exp_t_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL missing_event got=no change expected edge=%0d value=%b",
                     exp_t_q[0], exp_v_q[0]);
            void'(exp_t_q.pop_front());
            void'(exp_v_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ped_request
`default_nettype wire
